mips_hazard_scoreboard: RTL and testbench
=========================================

Name: mips_hazard_scoreboard

Overview:
- Parametrised RAW-hazard scoreboard for the pipe_MIPS32 family.
- Sits beside the ID stage and stalls issue while a source register has an in-flight write.
- Removes the need for dummy OR R7,R7,R7 padding between dependent instructions.
- Tracks destination registers through a configurable number of post-issue stages, with optional same-cycle writeback bypass.

Parameters:
- NREG, 32: architectural register count; register 0 is hardwired zero.
- ADDR_W, 5: register index width; NREG <= 2**ADDR_W.
- PIPE_DEPTH, 3: cycles from issue to writeback, i.e. the number of tracked slots; must be >= 1.
- BYPASS_LAST, 1: if 1, a source match against the final slot (the writeback cycle) does not stall.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID stage presents an instruction.
- issue_rs  in  ADDR_W  first source index.
- issue_rs_used  in  1  instruction reads rs.
- issue_rt  in  ADDR_W  second source index.
- issue_rt_used  in  1  instruction reads rt.
- issue_rd  in  ADDR_W  destination index.
- issue_wr  in  1  instruction writes rd.
- flush  in  1  synchronous clear of all in-flight tracking (branch or halt restart).
- issue_stall  out  1  combinational; hold the ID stage this cycle.
- wb_valid  out  1  the tracked write is in its final slot this cycle.
- wb_rd  out  ADDR_W  destination in the final slot; 0 when wb_valid=0.
- busy_mask  out  NREG  bit r set while any valid slot holds rd=r.
- inflight_cnt  out  $clog2(PIPE_DEPTH+1)  number of valid slots.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: PIPE_DEPTH slots, each holding {v, rd}, plus stall_cnt. No other storage.
- Reset (async, rst_n=0): all slot v=0, rd=0, stall_cnt=0. Consequently issue_stall=0, wb_valid=0, wb_rd=0, busy_mask=0, inflight_cnt=0. Reset asserted mid-operation discards all in-flight entries immediately.
- Hazard on a source: its used bit = 1, index != 0, and some slot k has v=1 and rd equal to the index.
  - With BYPASS_LAST=1, slot PIPE_DEPTH-1 is excluded from the match.
- issue_stall = issue_valid & ~flush & (hazard on rs | hazard on rt). Purely combinational from the inputs and slot registers.
- fire = issue_valid & ~issue_stall & ~flush.
- Every clk1 edge without flush:
  - slot[k] <= slot[k-1] for k = 1..PIPE_DEPTH-1.
  - slot[0] <= {fire & issue_wr & (issue_rd != 0), issue_rd}.
  - A stall inserts a bubble (v=0) into slot 0.
- flush=1 at an edge: every slot v <= 0. The issue presented in the same cycle is not recorded. stall_cnt is not cleared.
- Latency: a producer fired in cycle t occupies slot k-1 during cycle t+k, for k = 1..PIPE_DEPTH. The earliest dependent fire is:
  - cycle t+PIPE_DEPTH when BYPASS_LAST=1;
  - cycle t+PIPE_DEPTH+1 when BYPASS_LAST=0.
- Independent instructions never stall; back-to-back issue sustains one per cycle.
- wb_valid and wb_rd reflect slot[PIPE_DEPTH-1] directly.
- busy_mask is the OR over valid slots of the one-hot decode of rd. Bit 0 is always 0.
- inflight_cnt is the population count of slot v bits.
- Duplicate rd in flight: the register stays busy until the youngest copy leaves the tracked window.
- stall_cnt increments by 1 on each edge where issue_stall=1 and saturates at 2**CNT_W-1.
- PIPE_DEPTH=1 with BYPASS_LAST=1: issue_stall is never asserted (legal configuration).
- No X propagation: unused source indices may carry any value.

Test Plan:
- Reset mid-operation: 3 writers in flight, pull rst_n low between edges -> busy_mask=0, inflight_cnt=0, wb_valid=0, issue_stall=0 immediately, with no clock edge.
- RAW with default parameters: fire rd=1 wr=1 in cycle 0, then hold rs=1 rs_used=1 valid -> issue_stall=1 in cycles 1-2 and fire in cycle 3, stall_cnt=2. Repeat with BYPASS_LAST=0 -> fire in cycle 4, stall_cnt=3.
- Zero register and unused source:
  - writer with rd=0 -> inflight_cnt stays 0 and busy_mask=0.
  - with R1 busy, a consumer using rs=0, or with rs=1 but rs_used=0 -> no stall.
- Pipelined writers R1, R2, R3 fired in cycles 0, 1, 2:
  - inflight_cnt=1, 2, 3 and busy_mask=0x2, 0x6, 0xE in cycles 1, 2, 3;
  - wb_valid with wb_rd=1, 2, 3 in cycles 3, 4, 5;
  - then ADD rs=4 rt=3 fires in cycle 5 (slot-2 bypass), i.e. 10+20+25 sequencing with no padding.
- flush: 3 writers in flight plus a stalled consumer of R3, with flush=1 and a new writer rd=5 in the same cycle -> next cycle busy_mask=0, inflight_cnt=0, rd=5 not tracked, and the consumer fires that cycle.
- Saturation with CNT_W=4: hold a hazard for 20 stall cycles -> stall_cnt reads 15 and stays 15.

Source files
------------

// File: rtl/mips_hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the RAW-hazard scoreboard.
// The ID stage is the master; the scoreboard is the slave and answers with stall/status.
interface mips_hazard_scoreboard_if #(
   parameter int NREG       = 32,
   parameter int ADDR_W     = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int CNT_W      = 16
);
   localparam int CW = $clog2(PIPE_DEPTH + 1);

   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rs;
   logic              issue_rs_used;
   logic [ADDR_W-1:0] issue_rt;
   logic              issue_rt_used;
   logic [ADDR_W-1:0] issue_rd;
   logic              issue_wr;
   logic              flush;
   logic              issue_stall;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_rd;
   logic [NREG-1:0]   busy_mask;
   logic [CW-1:0]     inflight_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
             issue_rd, issue_wr, flush,
      input  issue_stall, wb_valid, wb_rd, busy_mask, inflight_cnt, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
             issue_rd, issue_wr, flush,
      output issue_stall, wb_valid, wb_rd, busy_mask, inflight_cnt, stall_cnt
   );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// RAW-hazard scoreboard beside the ID stage: tracks in-flight destination registers
// through PIPE_DEPTH slots and holds issue while a used source is still being produced.
module mips_hazard_scoreboard #(
   parameter int NREG        = 32,
   parameter int ADDR_W      = 5,
   parameter int PIPE_DEPTH  = 3,
   parameter int BYPASS_LAST = 1,
   parameter int CNT_W       = 16
) (
   input  logic                      clk1,
   input  logic                      rst_n,
   mips_hazard_scoreboard_if.slave   hz
);
   localparam int CW      = $clog2(PIPE_DEPTH + 1);
   localparam int MATCH_N = (BYPASS_LAST != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

   logic [PIPE_DEPTH-1:0]             slotV_q, slotV_d;
   logic [PIPE_DEPTH-1:0][ADDR_W-1:0] slotRd_q, slotRd_d;
   logic [CNT_W-1:0]                  stallCnt_q, stallCnt_d;
   logic                              hazRs, hazRt, stall, fire;

   // The writeback slot is left out of the match when the register file forwards same-cycle.
   always_comb begin
      hazRs = 1'b0;
      hazRt = 1'b0;
      for (int k = 0; k < MATCH_N; k++) begin
         if (slotV_q[k] && (slotRd_q[k] == hz.issue_rs)) hazRs = 1'b1;
         if (slotV_q[k] && (slotRd_q[k] == hz.issue_rt)) hazRt = 1'b1;
      end
      hazRs = hazRs & hz.issue_rs_used & (hz.issue_rs != '0);
      hazRt = hazRt & hz.issue_rt_used & (hz.issue_rt != '0);
   end

   assign stall = hz.issue_valid & ~hz.flush & (hazRs | hazRt);
   assign fire  = hz.issue_valid & ~stall & ~hz.flush;

   always_comb begin
      slotV_d     = '0;
      slotRd_d    = '0;
      slotV_d[0]  = fire & hz.issue_wr & (hz.issue_rd != '0);
      slotRd_d[0] = hz.issue_rd;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         slotV_d[k]  = slotV_q[k-1];
         slotRd_d[k] = slotRd_q[k-1];
      end
      if (hz.flush) slotV_d = '0;
      stallCnt_d = stallCnt_q;
      if (stall && !(&stallCnt_q)) stallCnt_d = stallCnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         slotV_q    <= '0;
         slotRd_q   <= '0;
         stallCnt_q <= '0;
      end else begin
         slotV_q    <= slotV_d;
         slotRd_q   <= slotRd_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   always_comb begin
      hz.busy_mask    = '0;
      hz.inflight_cnt = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         if (slotV_q[k] && (int'(slotRd_q[k]) < NREG)) hz.busy_mask[slotRd_q[k]] = 1'b1;
         hz.inflight_cnt = hz.inflight_cnt + CW'(slotV_q[k]);
      end
      hz.busy_mask[0] = 1'b0;
   end

   assign hz.issue_stall = stall;
   assign hz.wb_valid    = slotV_q[PIPE_DEPTH-1];
   assign hz.wb_rd       = slotV_q[PIPE_DEPTH-1] ? slotRd_q[PIPE_DEPTH-1] : '0;
   assign hz.stall_cnt   = stallCnt_q;
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Scoreboard bench for mips_hazard_scoreboard: four configurations side by side,
// directed stimulus queues expected values that a negedge monitor pops and compares.
module tb_mips_hazard_scoreboard;
   localparam int F_STALL = 0;
   localparam int F_WBV   = 1;
   localparam int F_WBRD  = 2;
   localparam int F_BUSY  = 3;
   localparam int F_INFL  = 4;
   localparam int F_CNT   = 5;

   typedef struct {
      int          cyc;
      int          d;
      int          f;
      logic [31:0] want;
      string       name;
   } expItem_t;

   logic clk1;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   expItem_t expQ[$];

   logic       stValid[4];
   logic [4:0] stRs[4];
   logic       stRsU[4];
   logic [4:0] stRt[4];
   logic       stRtU[4];
   logic [4:0] stRd[4];
   logic       stWr[4];
   logic       stFlush[4];

   logic        obsStall[4];
   logic        obsWbv[4];
   logic [31:0] obsWbRd[4];
   logic [31:0] obsBusy[4];
   logic [31:0] obsInfl[4];
   logic [31:0] obsCnt[4];

   // Configurations: 0 default, 1 no bypass, 2 narrow stall counter, 3 single-slot pipe
   genvar g;
   for (g = 0; g < 4; g++) begin : gDut
      mips_hazard_scoreboard_if #(
         .NREG(32), .ADDR_W(5), .PIPE_DEPTH(g == 3 ? 1 : 3), .CNT_W(g == 2 ? 4 : 16)
      ) bus ();

      mips_hazard_scoreboard #(
         .NREG(32), .ADDR_W(5), .PIPE_DEPTH(g == 3 ? 1 : 3),
         .BYPASS_LAST(g == 1 ? 0 : 1), .CNT_W(g == 2 ? 4 : 16)
      ) dut (
         .clk1  (clk1),
         .rst_n (rst_n),
         .hz    (bus)
      );

      assign bus.issue_valid   = stValid[g];
      assign bus.issue_rs      = stRs[g];
      assign bus.issue_rs_used = stRsU[g];
      assign bus.issue_rt      = stRt[g];
      assign bus.issue_rt_used = stRtU[g];
      assign bus.issue_rd      = stRd[g];
      assign bus.issue_wr      = stWr[g];
      assign bus.flush         = stFlush[g];
      assign obsStall[g] = bus.issue_stall;
      assign obsWbv[g]   = bus.wb_valid;
      assign obsWbRd[g]  = 32'(bus.wb_rd);
      assign obsBusy[g]  = bus.busy_mask;
      assign obsInfl[g]  = 32'(bus.inflight_cnt);
      assign obsCnt[g]   = 32'(bus.stall_cnt);
   end

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   initial cyc = 0;
   always @(posedge clk1) cyc = cyc + 1;

   function automatic logic [31:0] actual(int d, int f);
      case (f)
         F_STALL: return 32'(obsStall[d]);
         F_WBV:   return 32'(obsWbv[d]);
         F_WBRD:  return obsWbRd[d];
         F_BUSY:  return obsBusy[d];
         F_INFL:  return obsInfl[d];
         default: return obsCnt[d];
      endcase
   endfunction

   // Monitor: every expectation tagged for this cycle is compared mid-cycle, away from the edge
   always @(negedge clk1) begin
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         expItem_t it;
         logic [31:0] got;
         it = expQ.pop_front();
         got = actual(it.d, it.f);
         total = total + 1;
         if (it.cyc != cyc || got !== it.want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s dut%0d cycle=%0d got=0x%0h want=0x%0h",
                     it.name, it.d, cyc, got, it.want);
         end
      end
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic applyStimulus(int d, logic v, logic [4:0] rs, logic rsU, logic [4:0] rt,
                                logic rtU, logic [4:0] rd, logic wr, logic fl);
      stValid[d] = v;
      stRs[d]    = rs;
      stRsU[d]   = rsU;
      stRt[d]    = rt;
      stRtU[d]   = rtU;
      stRd[d]    = rd;
      stWr[d]    = wr;
      stFlush[d] = fl;
   endtask

   task automatic idle(int d);
      applyStimulus(d, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
   endtask

   task automatic writer(int d, logic [4:0] rd);
      applyStimulus(d, 1, 5'd0, 0, 5'd0, 0, rd, 1, 0);
   endtask

   task automatic checkOutput(int d, int f, logic [31:0] want, string name);
      expItem_t it;
      it.cyc  = cyc;
      it.d    = d;
      it.f    = f;
      it.want = want;
      it.name = name;
      expQ.push_back(it);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int d = 0; d < 4; d++) idle(d);
      tick();
      for (int d = 0; d < 4; d++) begin
         for (int f = 0; f < 6; f++) checkOutput(d, f, 32'd0, "reset_state");
      end
      tick();
      rst_n = 1'b1;

      // Writer to R0 is never tracked
      writer(0, 5'd0);
      checkOutput(0, F_STALL, 0, "zero_rd_issue");
      tick();
      idle(0);
      checkOutput(0, F_INFL, 0, "zero_rd_infl");
      checkOutput(0, F_BUSY, 0, "zero_rd_busy");
      tick();

      // RAW on R1: bypass fires in cycle 3, no bypass in cycle 4
      writer(0, 5'd1);
      writer(1, 5'd1);
      tick();
      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, 1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0);
         checkOutput(d, F_STALL, 1, "raw_c1");
      end
      tick();
      checkOutput(0, F_STALL, 1, "raw_c2");
      checkOutput(1, F_STALL, 1, "raw_c2");
      tick();
      checkOutput(0, F_STALL, 0, "raw_bypass_fire");
      checkOutput(0, F_CNT, 2, "raw_bypass_cnt");
      checkOutput(0, F_WBV, 1, "raw_wbv");
      checkOutput(0, F_WBRD, 1, "raw_wbrd");
      checkOutput(1, F_STALL, 1, "raw_nobyp_c3");
      tick();
      idle(0);
      checkOutput(1, F_STALL, 0, "raw_nobyp_fire");
      checkOutput(1, F_CNT, 3, "raw_nobyp_cnt");
      tick();
      idle(1);

      // Unused and zero sources never stall; a used rt does
      writer(0, 5'd1);
      tick();
      applyStimulus(0, 1, 5'd1, 0, 5'd0, 1, 5'd0, 0, 0);
      checkOutput(0, F_STALL, 0, "src_unused_or_zero");
      tick();
      applyStimulus(0, 1, 5'd0, 0, 5'd1, 1, 5'd0, 0, 0);
      checkOutput(0, F_STALL, 1, "rt_hazard");
      tick();
      checkOutput(0, F_STALL, 0, "rt_bypass_fire");
      checkOutput(0, F_CNT, 3, "rt_cnt");
      tick();
      idle(0);
      tick();
      tick();
      tick();

      // Pipelined writers R1,R2,R3 then ADD rs=4 rt=3 rd=5 with no padding
      writer(0, 5'd1);
      checkOutput(0, F_STALL, 0, "pipe_w1");
      tick();
      writer(0, 5'd2);
      checkOutput(0, F_INFL, 1, "pipe_infl1");
      checkOutput(0, F_BUSY, 32'h2, "pipe_busy1");
      tick();
      writer(0, 5'd3);
      checkOutput(0, F_INFL, 2, "pipe_infl2");
      checkOutput(0, F_BUSY, 32'h6, "pipe_busy2");
      tick();
      applyStimulus(0, 1, 5'd4, 1, 5'd3, 1, 5'd5, 1, 0);
      checkOutput(0, F_INFL, 3, "pipe_infl3");
      checkOutput(0, F_BUSY, 32'hE, "pipe_busy3");
      checkOutput(0, F_WBV, 1, "pipe_wbv3");
      checkOutput(0, F_WBRD, 1, "pipe_wbrd3");
      checkOutput(0, F_STALL, 1, "pipe_add_c3");
      tick();
      checkOutput(0, F_STALL, 1, "pipe_add_c4");
      checkOutput(0, F_WBRD, 2, "pipe_wbrd4");
      checkOutput(0, F_INFL, 2, "pipe_infl4");
      checkOutput(0, F_BUSY, 32'hC, "pipe_busy4");
      tick();
      checkOutput(0, F_STALL, 0, "pipe_add_fire");
      checkOutput(0, F_WBV, 1, "pipe_wbv5");
      checkOutput(0, F_WBRD, 3, "pipe_wbrd5");
      tick();
      idle(0);
      checkOutput(0, F_BUSY, 32'h20, "pipe_add_busy");
      checkOutput(0, F_INFL, 1, "pipe_add_infl");
      checkOutput(0, F_WBV, 0, "pipe_wbv6");
      checkOutput(0, F_WBRD, 0, "pipe_wbrd6");
      tick();
      tick();
      tick();

      // Flush with a stalled R3 consumer and a same-cycle writer of R5
      writer(0, 5'd1);
      tick();
      writer(0, 5'd2);
      tick();
      writer(0, 5'd3);
      tick();
      applyStimulus(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0);
      checkOutput(0, F_STALL, 1, "flush_pre_stall");
      tick();
      applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
      checkOutput(0, F_STALL, 0, "flush_no_stall");
      tick();
      applyStimulus(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0);
      checkOutput(0, F_STALL, 0, "flush_consumer_fire");
      checkOutput(0, F_BUSY, 0, "flush_busy");
      checkOutput(0, F_INFL, 0, "flush_infl");
      checkOutput(0, F_WBV, 0, "flush_wbv");
      checkOutput(0, F_CNT, 6, "flush_cnt_kept");
      tick();
      idle(0);
      checkOutput(0, F_INFL, 0, "flush_rd5_untracked");
      checkOutput(0, F_BUSY, 0, "flush_busy_after");

      // Reset mid-operation clears everything without a clock edge
      writer(0, 5'd1);
      tick();
      writer(0, 5'd2);
      tick();
      writer(0, 5'd3);
      checkOutput(0, F_INFL, 2, "rstmid_pre_infl");
      tick();
      applyStimulus(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0);
      rst_n = 1'b0;
      checkOutput(0, F_STALL, 0, "rstmid_stall");
      checkOutput(0, F_BUSY, 0, "rstmid_busy");
      checkOutput(0, F_INFL, 0, "rstmid_infl");
      checkOutput(0, F_WBV, 0, "rstmid_wbv");
      checkOutput(0, F_CNT, 0, "rstmid_cnt");
      tick();
      idle(0);
      rst_n = 1'b1;
      tick();

      // Single-slot pipe with bypass never stalls
      writer(3, 5'd1);
      tick();
      applyStimulus(3, 1, 5'd1, 1, 5'd1, 1, 5'd0, 0, 0);
      checkOutput(3, F_STALL, 0, "depth1_no_stall");
      checkOutput(3, F_WBV, 1, "depth1_wbv");
      checkOutput(3, F_WBRD, 1, "depth1_wbrd");
      checkOutput(3, F_BUSY, 32'h2, "depth1_busy");
      checkOutput(3, F_INFL, 1, "depth1_infl");
      tick();
      idle(3);

      // Self-dependent writer of R1: stalls two of every three cycles until the counter saturates
      for (int i = 0; i <= 30; i++) begin
         applyStimulus(2, 1, 5'd1, 1, 5'd0, 0, 5'd1, 1, 0);
         checkOutput(2, F_STALL, (i % 3 != 0) ? 32'd1 : 32'd0, "sat_stall");
         if (i == 22) checkOutput(2, F_CNT, 14, "sat_cnt_14");
         if (i == 23) checkOutput(2, F_CNT, 15, "sat_cnt_15");
         if (i == 30) checkOutput(2, F_CNT, 15, "sat_cnt_hold");
         tick();
      end
      idle(2);
      tick();
      tick();

      total = total + 1;
      if (expQ.size() != 0) begin
         bad = bad + 1;
         $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
